// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM control into a valid/ready data-memory
// transaction, stalls the front end while it is outstanding and extends load data.
module mem_stage_lsu #(
    parameter int RSP_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_write_en_in,
    input  logic        MemtoReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rs2_data_in,
    input  logic [4:0]  rd_addr_in,
    input  logic [2:0]  funct3_in,
    output logic        stall_out,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_req_we,
    output logic [31:0] dmem_req_addr,
    output logic [31:0] dmem_req_wdata,
    output logic [3:0]  dmem_req_be,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_rdata,
    output logic        reg_write_en_out,
    output logic        MemtoReg_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] mem_rdata_out,
    output logic [4:0]  rd_addr_out,
    output logic        misalign_out,
    output logic        timeout_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic             WD_EN_C   = (RSP_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] WD_LAST_C = CNT_W'(RSP_TIMEOUT - 1);

    // Illegal funct3, conflicting read/write, or size-misaligned address.
    function automatic logic access_fault(input logic ld, input logic st,
                                          input logic [2:0] f3, input logic [1:0] a);
        logic f;
        f = 1'b0;
        if (ld && st) begin
            f = 1'b1;
        end else if (ld) begin
            case (f3)
                3'b000, 3'b100: f = 1'b0;
                3'b001, 3'b101: f = a[0];
                3'b010:         f = (a != 2'b00);
                default:        f = 1'b1;
            endcase
        end else if (st) begin
            case (f3)
                3'b000:  f = 1'b0;
                3'b001:  f = a[0];
                3'b010:  f = (a != 2'b00);
                default: f = 1'b1;
            endcase
        end else begin
            f = 1'b0;
        end
        return f;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3)
            3'b000:  be = 4'b0001 << a;
            3'b001:  be = a[1] ? 4'b1100 : 4'b0011;
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3)
            3'b000:  w = {4{d[7:0]}};
            3'b001:  w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = w;
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   wd_r;
    logic               cap_we_r, cap_rw_r, cap_m2r_r, timeout_r;
    logic [31:0]        cap_addr_r, cap_wdata_r, rdata_r;
    logic [3:0]         cap_be_r;
    logic [2:0]         cap_f3_r;
    logic [4:0]         cap_rd_r;
    logic               mem_op_s, fault_s, capture_s, rsp_take_s, timeout_hit_s;

    assign mem_op_s = MemRead_in | MemWrite_in;
    assign fault_s  = access_fault(MemRead_in, MemWrite_in, funct3_in, alu_result_in[1:0]);

    // Next-state and output decode; IDLE passes EX/MEM fields straight through.
    always_comb begin
        state_nxt_s      = state_r;
        capture_s        = 1'b0;
        rsp_take_s       = 1'b0;
        timeout_hit_s    = 1'b0;
        stall_out        = 1'b0;
        dmem_req_valid   = 1'b0;
        dmem_req_we      = 1'b0;
        dmem_req_addr    = 32'h0000_0000;
        dmem_req_wdata   = 32'h0000_0000;
        dmem_req_be      = 4'b0000;
        reg_write_en_out = reg_write_en_in;
        MemtoReg_out     = MemtoReg_in;
        alu_result_out   = alu_result_in;
        rd_addr_out      = rd_addr_in;
        mem_rdata_out    = 32'h0000_0000;
        misalign_out     = 1'b0;
        timeout_out      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (mem_op_s && fault_s) begin
                    misalign_out     = 1'b1;
                    reg_write_en_out = 1'b0;
                end else if (mem_op_s) begin
                    stall_out   = 1'b1;
                    capture_s   = 1'b1;
                    state_nxt_s = S_REQ;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_REQ: begin
                stall_out        = 1'b1;
                dmem_req_valid   = 1'b1;
                dmem_req_we      = cap_we_r;
                dmem_req_addr    = {cap_addr_r[31:2], 2'b00};
                dmem_req_wdata   = cap_wdata_r;
                dmem_req_be      = cap_be_r;
                reg_write_en_out = 1'b0;
                MemtoReg_out     = cap_m2r_r;
                alu_result_out   = cap_addr_r;
                rd_addr_out      = cap_rd_r;
                if (dmem_req_ready) begin
                    state_nxt_s = cap_we_r ? S_DONE : S_RSP;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_RSP: begin
                stall_out        = 1'b1;
                reg_write_en_out = 1'b0;
                MemtoReg_out     = cap_m2r_r;
                alu_result_out   = cap_addr_r;
                rd_addr_out      = cap_rd_r;
                if (dmem_rsp_valid) begin
                    rsp_take_s  = 1'b1;
                    state_nxt_s = S_DONE;
                end else if (WD_EN_C && (wd_r == WD_LAST_C)) begin
                    timeout_hit_s = 1'b1;
                    state_nxt_s   = S_DONE;
                end else begin
                    state_nxt_s = S_RSP;
                end
            end
            S_DONE: begin
                reg_write_en_out = cap_rw_r & ~timeout_r;
                MemtoReg_out     = cap_m2r_r;
                alu_result_out   = cap_addr_r;
                rd_addr_out      = cap_rd_r;
                mem_rdata_out    = rdata_r;
                timeout_out      = timeout_r;
                state_nxt_s      = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State, capture registers, load result and response watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            wd_r        <= '0;
            cap_we_r    <= 1'b0;
            cap_rw_r    <= 1'b0;
            cap_m2r_r   <= 1'b0;
            cap_addr_r  <= 32'h0000_0000;
            cap_wdata_r <= 32'h0000_0000;
            cap_be_r    <= 4'b0000;
            cap_f3_r    <= 3'b000;
            cap_rd_r    <= 5'd0;
            rdata_r     <= 32'h0000_0000;
            timeout_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            wd_r    <= (state_r == S_RSP) ? wd_r + CNT_W'(1) : '0;
            if (capture_s) begin
                cap_we_r    <= MemWrite_in;
                cap_rw_r    <= reg_write_en_in;
                cap_m2r_r   <= MemtoReg_in;
                cap_addr_r  <= alu_result_in;
                cap_wdata_r <= store_wdata(funct3_in, rs2_data_in);
                cap_be_r    <= MemWrite_in ? store_be(funct3_in, alu_result_in[1:0]) : 4'b0000;
                cap_f3_r    <= funct3_in;
                cap_rd_r    <= rd_addr_in;
                rdata_r     <= 32'h0000_0000;
                timeout_r   <= 1'b0;
            end
            if (rsp_take_s) begin
                rdata_r <= load_extend(cap_f3_r, cap_addr_r[1:0], dmem_rsp_rdata);
            end
            if (timeout_hit_s) begin
                timeout_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (watchdog shortened to 4 cycles).
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write_en_in, MemtoReg_in, MemRead_in, MemWrite_in;
    logic [31:0] alu_result_in, rs2_data_in;
    logic [4:0]  rd_addr_in;
    logic [2:0]  funct3_in;
    logic        stall_out, dmem_req_valid, dmem_req_ready, dmem_req_we;
    logic [31:0] dmem_req_addr, dmem_req_wdata;
    logic [3:0]  dmem_req_be;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic        reg_write_en_out, MemtoReg_out;
    logic [31:0] alu_result_out, mem_rdata_out;
    logic [4:0]  rd_addr_out;
    logic        misalign_out, timeout_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.RSP_TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .reg_write_en_in(reg_write_en_in), .MemtoReg_in(MemtoReg_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in),
        .rd_addr_in(rd_addr_in), .funct3_in(funct3_in),
        .stall_out(stall_out), .dmem_req_valid(dmem_req_valid),
        .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we),
        .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata),
        .dmem_req_be(dmem_req_be), .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rsp_rdata(dmem_rsp_rdata),
        .reg_write_en_out(reg_write_en_out), .MemtoReg_out(MemtoReg_out),
        .alu_result_out(alu_result_out), .mem_rdata_out(mem_rdata_out),
        .rd_addr_out(rd_addr_out), .misalign_out(misalign_out),
        .timeout_out(timeout_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop(input logic [31:0] alu, input logic [4:0] rd, input logic rw);
        reg_write_en_in = rw;
        MemtoReg_in     = 1'b0;
        MemRead_in      = 1'b0;
        MemWrite_in     = 1'b0;
        alu_result_in   = alu;
        rs2_data_in     = 32'h0;
        rd_addr_in      = rd;
        funct3_in       = 3'b000;
    endtask

    task automatic set_mem(input logic ld, input logic st, input logic [31:0] addr,
                           input logic [31:0] data, input logic [2:0] f3);
        reg_write_en_in = ld;
        MemtoReg_in     = ld;
        MemRead_in      = ld;
        MemWrite_in     = st;
        alu_result_in   = addr;
        rs2_data_in     = data;
        rd_addr_in      = 5'd7;
        funct3_in       = f3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_rdata = 32'h0;
        set_nop(32'h0000_AAAA, 5'd3, 1'b1);
        tick(); tick();
        @(negedge clk);
        n_cmp++;
        if ({stall_out, dmem_req_valid, dmem_req_we, misalign_out, timeout_out} !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 00000", {stall_out, dmem_req_valid, dmem_req_we, misalign_out, timeout_out});
        end
        n_cmp++;
        if ({dmem_req_addr, dmem_req_wdata, dmem_req_be} !== 68'h0) begin
            n_bad++;
            $display("FAIL reset_bus: got %h/%h/%b want zeros", dmem_req_addr, dmem_req_wdata, dmem_req_be);
        end
        n_cmp++;
        if (alu_result_out !== 32'h0000_AAAA || rd_addr_out !== 5'd3 || mem_rdata_out !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_passthru: got %h rd %0d rdata %h want 0000aaaa rd 3 rdata 0", alu_result_out, rd_addr_out, mem_rdata_out);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_passthrough();
        set_nop(32'h0000_1234, 5'd5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (alu_result_out !== 32'h1234 || rd_addr_out !== 5'd5 || reg_write_en_out !== 1'b1
                || stall_out !== 1'b0 || dmem_req_valid !== 1'b0 || mem_rdata_out !== 32'h0) begin
                n_bad++;
                $display("FAIL passthru[%0d]: got alu %h rd %0d rw %b stall %b valid %b rdata %h", i,
                         alu_result_out, rd_addr_out, reg_write_en_out, stall_out, dmem_req_valid, mem_rdata_out);
            end
            tick();
        end
        set_nop(32'h0000_5678, 5'd6, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (alu_result_out !== 32'h5678 || reg_write_en_out !== 1'b0) begin
            n_bad++;
            $display("FAIL passthru_comb: got alu %h rw %b want 00005678 0", alu_result_out, reg_write_en_out);
        end
        tick();
    endtask

    task automatic run_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] exp_addr,
                             input logic [31:0] exp_wdata, input logic [3:0] exp_be);
        set_mem(1'b0, 1'b1, addr, data, f3);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (stall_out !== 1'b1 || dmem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s idle: got stall %b valid %b want 1 0", name, stall_out, dmem_req_valid);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (dmem_req_valid !== 1'b1 || dmem_req_we !== 1'b1 || stall_out !== 1'b1 || dmem_req_addr !== exp_addr
            || dmem_req_wdata !== exp_wdata || dmem_req_be !== exp_be) begin
            n_bad++;
            $display("FAIL %s req: got v%b we%b st%b addr %h wdata %h be %b want 1 1 1 %h %h %b", name,
                     dmem_req_valid, dmem_req_we, stall_out, dmem_req_addr, dmem_req_wdata, dmem_req_be,
                     exp_addr, exp_wdata, exp_be);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (stall_out !== 1'b0 || dmem_req_valid !== 1'b0 || alu_result_out !== addr || reg_write_en_out !== 1'b0) begin
            n_bad++;
            $display("FAIL %s done: got st%b v%b alu %h rw %b want 0 0 %h 0", name,
                     stall_out, dmem_req_valid, alu_result_out, reg_write_en_out, addr);
        end
        tick();
        dmem_req_ready = 1'b0;
        set_nop(32'h0, 5'd0, 1'b0);
    endtask

    task automatic run_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] word, input logic [31:0] exp, input int rdy_dly, input int rsp_dly);
        set_mem(1'b1, 1'b0, addr, 32'h0, f3);
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'h1234_5678;
        @(negedge clk);
        n_cmp++;
        if (stall_out !== 1'b1) begin
            n_bad++;
            $display("FAIL %s idle_stall: got %b want 1", name, stall_out);
        end
        tick();
        for (int i = 0; i <= rdy_dly; i++) begin
            dmem_req_ready = (i == rdy_dly);
            @(negedge clk);
            n_cmp++;
            if (dmem_req_valid !== 1'b1 || dmem_req_we !== 1'b0 || dmem_req_addr !== {addr[31:2], 2'b00}) begin
                n_bad++;
                $display("FAIL %s req[%0d]: got v%b we%b addr %h want 1 0 %h", name, i,
                         dmem_req_valid, dmem_req_we, dmem_req_addr, {addr[31:2], 2'b00});
            end
            tick();
        end
        dmem_req_ready = 1'b0;
        for (int i = 0; i <= rsp_dly; i++) begin
            dmem_rsp_valid = (i == rsp_dly);
            dmem_rsp_rdata = (i == rsp_dly) ? word : 32'h5A5A_5A5A;
            @(negedge clk);
            n_cmp++;
            if (stall_out !== 1'b1 || dmem_req_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL %s rsp[%0d]: got stall %b valid %b want 1 0", name, i, stall_out, dmem_req_valid);
            end
            tick();
        end
        dmem_rsp_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_rdata_out !== exp || reg_write_en_out !== 1'b1 || MemtoReg_out !== 1'b1 || rd_addr_out !== 5'd7
            || alu_result_out !== addr || stall_out !== 1'b0 || timeout_out !== 1'b0) begin
            n_bad++;
            $display("FAIL %s done: got rdata %h rw %b m2r %b rd %0d alu %h st %b to %b want %h 1 1 7 %h 0 0", name,
                     mem_rdata_out, reg_write_en_out, MemtoReg_out, rd_addr_out, alu_result_out, stall_out,
                     timeout_out, exp, addr);
        end
        tick();
        set_nop(32'h0, 5'd0, 1'b0);
    endtask

    task automatic test_store();
        run_store("sw", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111);
        run_store("sh", 3'b001, 32'h0000_0042, 32'h0000_ABCD, 32'h0000_0040, 32'hABCD_ABCD, 4'b1100);
        run_store("sb", 3'b000, 32'h0000_0101, 32'h1122_3355, 32'h0000_0100, 32'h5555_5555, 4'b0010);
    endtask

    task automatic test_load();
        run_load("lb",  3'b000, 32'h0000_0203, 32'h80FF_0000, 32'hFFFF_FF80, 2, 3);
        run_load("lbu", 3'b100, 32'h0000_0203, 32'h80FF_0000, 32'h0000_0080, 2, 3);
        run_load("lh",  3'b001, 32'h0000_0202, 32'h80FF_0000, 32'hFFFF_80FF, 0, 0);
        run_load("lhu", 3'b101, 32'h0000_0200, 32'h1234_9ABC, 32'h0000_9ABC, 1, 0);
        run_load("lw",  3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 0);
    endtask

    task automatic check_fault(input string name, input logic ld, input logic st,
                               input logic [31:0] addr, input logic [2:0] f3);
        set_mem(ld, st, addr, 32'h0, f3);
        reg_write_en_in = 1'b1;
        dmem_req_ready  = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (misalign_out !== 1'b1 || reg_write_en_out !== 1'b0 || stall_out !== 1'b0 || dmem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got mis %b rw %b st %b v %b want 1 0 0 0", name,
                     misalign_out, reg_write_en_out, stall_out, dmem_req_valid);
        end
        tick();
        set_nop(32'h0, 5'd0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (misalign_out !== 1'b0 || dmem_req_valid !== 1'b0 || stall_out !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_after: got mis %b v %b st %b want 0 0 0", name, misalign_out, dmem_req_valid, stall_out);
        end
        tick();
        dmem_req_ready = 1'b0;
    endtask

    task automatic test_misalign();
        check_fault("lw_misalign", 1'b1, 1'b0, 32'h0000_0101, 3'b010);
        check_fault("sh_misalign", 1'b0, 1'b1, 32'h0000_0043, 3'b001);
        check_fault("ld_bad_f3",   1'b1, 1'b0, 32'h0000_0100, 3'b011);
        check_fault("st_bad_f3",   1'b0, 1'b1, 32'h0000_0100, 3'b100);
        check_fault("rd_and_wr",   1'b1, 1'b1, 32'h0000_0100, 3'b010);
    endtask

    task automatic test_timeout();
        set_mem(1'b1, 1'b0, 32'h0000_0300, 32'h0, 3'b010);
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'b0;
        tick();
        tick();
        dmem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (stall_out !== 1'b1 || timeout_out !== 1'b0) begin
                n_bad++;
                $display("FAIL timeout_wait[%0d]: got stall %b to %b want 1 0", i, stall_out, timeout_out);
            end
            tick();
        end
        @(negedge clk);
        n_cmp++;
        if (timeout_out !== 1'b1 || reg_write_en_out !== 1'b0 || stall_out !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_done: got to %b rw %b st %b want 1 0 0", timeout_out, reg_write_en_out, stall_out);
        end
        tick();
        set_nop(32'h0, 5'd0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (timeout_out !== 1'b0 || stall_out !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_clear: got to %b st %b want 0 0", timeout_out, stall_out);
        end
        tick();
    endtask

    task automatic test_reset_in_req();
        set_mem(1'b1, 1'b0, 32'h0000_0400, 32'h0, 3'b010);
        dmem_req_ready = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++;
        if (dmem_req_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_req_pre: got valid %b want 1", dmem_req_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_nop(32'h0000_0777, 5'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            dmem_rsp_valid = 1'b1;
            dmem_rsp_rdata = 32'hFFFF_FFFF;
            dmem_req_ready = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (dmem_req_valid !== 1'b0 || stall_out !== 1'b0 || mem_rdata_out !== 32'h0
                || alu_result_out !== 32'h777 || timeout_out !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_req_after[%0d]: got v %b st %b rdata %h alu %h to %b want 0 0 0 777 0", i,
                         dmem_req_valid, stall_out, mem_rdata_out, alu_result_out, timeout_out);
            end
            tick();
        end
        dmem_rsp_valid = 1'b0;
        dmem_req_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_store("b2b_sw", 3'b010, 32'h0000_0010, 32'h0BAD_CAFE, 32'h0000_0010, 32'h0BAD_CAFE, 4'b1111);
        run_load("b2b_lb", 3'b000, 32'h0000_0011, 32'h0000_7F00, 32'h0000_007F, 0, 0);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_store();
        test_load();
        test_misalign();
        test_timeout();
        test_reset_in_req();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
